pipereg_skid: RTL and testbench

PIPEREG_SKID -- requirements
Module: pipereg_skid

---
 rtl/pipereg_skid_pkg.sv | 22 ++
 rtl/pipereg_skid_flopenrs.sv | 25 ++
 rtl/pipereg_skid.sv | 118 +++++++++++
 tb/tb_pipereg_skid.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipereg_skid_pkg.sv
// Shared types for the skid-buffered pipeline register.
// State encodings and the state-to-occupancy mapping.
package pipereg_skid_pkg;

    typedef enum logic [1:0] {
        PRS_EMPTY = 2'b00,
        PRS_BUSY  = 2'b01,
        PRS_FULL  = 2'b10
    } prs_state_e;

    function automatic logic [1:0] prs_occ(input prs_state_e s);
        logic [1:0] o;
        o = 2'd0;
        unique case (s)
            PRS_BUSY: o = 2'd1;
            PRS_FULL: o = 2'd2;
            default:  o = 2'd0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pipereg_skid_flopenrs.sv
// Data flop with synchronous reset, synchronous clear and enable.
// Reset and clear both load RESET_VAL; reset wins, then clear, then enable.
module flopenrs #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (clear) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipereg_skid.sv
// Two-entry skid pipeline register: main drives out_data, skid absorbs
// one extra payload so handshake outputs can be fully registered.
module pipereg_skid
    import pipereg_skid_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] FLUSH_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    prs_state_e       state_q;
    prs_state_e       state_n;
    logic [1:0]       occ_q;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_n        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_n = PRS_EMPTY;
        end else begin
            unique case (state_q)
                PRS_EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_n = PRS_BUSY;
                    end
                end
                PRS_BUSY: begin
                    if (in_fire && !out_fire) begin
                        skid_en = 1'b1;
                        state_n = PRS_FULL;
                    end else if (!in_fire && out_fire) begin
                        state_n = PRS_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end
                end
                PRS_FULL: begin
                    if (out_fire) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_n        = PRS_BUSY;
                    end
                end
                default: state_n = PRS_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    // Handshake outputs are precomputed from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PRS_EMPTY;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            occ_q      <= prs_occ(state_n);
            in_ready_q <= (state_n != PRS_FULL);
        end
    end

    flopenrs #(
        .WIDTH     (WIDTH),
        .RESET_VAL (FLUSH_DATA)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .clear (flush),
        .d     (main_d),
        .q     (main_q)
    );

    flopenrs #(
        .WIDTH     (WIDTH),
        .RESET_VAL (FLUSH_DATA)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .clear (flush),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != PRS_EMPTY);
    assign out_data  = main_q;
    assign occ       = occ_q;

endmodule

// File: tb/tb_pipereg_skid.sv
// Scoreboard bench for pipereg_skid: directed scenarios then random traffic,
// checked against a FIFO-of-payloads model of at most two entries.
module tb_pipereg_skid;

    localparam int           W     = 8;
    localparam logic [W-1:0] FDATA = 8'hA5;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    pipereg_skid #(
        .WIDTH      (W),
        .FLUSH_DATA (FDATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] q[$];
    bit           started   = 0;
    bit           rst_prev  = 1;
    bit           clean     = 1;
    bit           stall_prv = 0;
    logic [W-1:0] held;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Monitor: check the visible state, then apply the edge about to happen.
    always @(negedge clk) begin
        if (started) begin
            chk("occ", 64'(occ), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready),
                64'(!rst_prev && q.size() < 2));
            if (q.size() != 0)
                chk("out_data", 64'(out_data), 64'(q[0]));
            else if (clean)
                chk("flush_data", 64'(out_data), 64'(FDATA));
            if (stall_prv && out_valid)
                chk("stall_stable", 64'(out_data), 64'(held));
        end
        rst_prev = reset;
        if (reset || flush) begin
            q.delete();
            clean     = 1;
            stall_prv = 0;
            if (reset) started = 1;
        end else if (started) begin
            stall_prv = out_valid && !out_ready;
            held      = out_data;
            if (out_valid && out_ready && q.size() != 0)
                void'(q.pop_front());
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                clean = 0;
            end
        end
    end

    task automatic step(input bit iv, input logic [W-1:0] d,
                        input bit ordy, input bit fl, input bit rs);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        // streaming at full rate
        step(1, 8'h11, 1, 0, 0);
        step(1, 8'h11, 1, 0, 0);
        step(1, 8'h22, 1, 0, 0);
        step(1, 8'h33, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // backpressure fills skid, 0x0C held off then accepted
        step(1, 8'h0A, 0, 0, 0);
        step(1, 8'h0B, 0, 0, 0);
        step(1, 8'h0C, 0, 0, 0);
        step(1, 8'h0C, 1, 0, 0);
        step(1, 8'h0C, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // flush while full with a concurrent offer
        step(1, 8'h05, 0, 0, 0);
        step(1, 8'h06, 0, 0, 0);
        step(1, 8'h07, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // simultaneous in and out fire in BUSY
        step(1, 8'h08, 0, 0, 0);
        step(1, 8'h09, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // reset and flush together while full
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(1, 8'h03, 1, 1, 1);
        step(1, 8'h04, 1, 0, 1);
        step(1, 8'h04, 1, 0, 0);
        step(1, 8'h05, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 99) == 0);
        end
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
